// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count, programmable
// almost-full/almost-empty thresholds, selectable first-word-fall-through or
// registered read data, and one-cycle overflow/underflow error pulses.
module sync_fifo #(
    parameter int WIDTH         = 36,
    parameter int DEPTH         = 256,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     ren,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] AFULL_T  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_T = PW'(AEMPTY_THRESH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // Pointers carry one extra MSB that toggles on every wrap, so equal
    // addresses with differing MSBs mean full and identical pointers mean empty.
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic             rd_acc;
    logic             wr_acc;

    assign waddr = wptr_q[AW-1:0];
    assign raddr = rptr_q[AW-1:0];

    // Status is purely combinational from the registered pointers.
    assign empty        = (wptr_q == rptr_q);
    assign full         = (waddr == raddr) && (wptr_q[AW] != rptr_q[AW]);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AFULL_T);
    assign almost_empty = (count <= AEMPTY_T);

    // A read pops only a present word; a write into a full FIFO is allowed
    // when the same-cycle read frees a slot. No write-to-read bypass exists.
    assign rd_acc = ren & ~empty;
    assign wr_acc = wen & (~full | rd_acc);

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Next pointer values and error pulses for the coming edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = wen & ~wr_acc;
        underflow_d = ren & ~rd_acc;
        if (wr_acc) wptr_d = wptr_q + PTR_ONE;
        if (rd_acc) rptr_d = rptr_q + PTR_ONE;
    end

    // Pointer and error-pulse registers; reset wins over any request.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto block RAM; stale words are unreachable once the pointers clear.
        if (!rst && wr_acc) mem_q[waddr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; it is valid whenever the FIFO holds data.
            assign rdata  = mem_q[raddr];
            assign rvalid = ~empty;
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            // Registered read: capture the head on an accepted read, hold otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem_q[raddr];
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo. Two DEPTH=8 instances share one stimulus
// stream: one in FWFT mode with thresholds 6/2, one in registered-read mode
// with default thresholds (4/4). Outputs are compared against a queue model.
module tb_sync_fifo;

    localparam int WIDTH = 36;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             wen;
    logic             ren;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] f_rdata, r_rdata;
    logic             f_rvalid, r_rvalid;
    logic             f_empty, r_empty;
    logic             f_full, r_full;
    logic             f_ae, r_ae;
    logic             f_af, r_af;
    logic [3:0]       f_count, r_count;
    logic             f_ovf, r_ovf;
    logic             f_udf, r_udf;

    int checks   = 0;
    int failures = 0;

    sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
    ) u_fwft (
        .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(f_rdata), .rvalid(f_rvalid), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)
    ) u_reg (
        .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(r_rdata), .rvalid(r_rvalid), .empty(r_empty), .full(r_full),
        .almost_empty(r_ae), .almost_full(r_af), .count(r_count),
        .overflow(r_ovf), .underflow(r_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue plus the registered side outputs.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf;
    logic             m_udf;
    logic             m_rvalid_reg;
    logic [WIDTH-1:0] m_rdata_reg;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic rs);
        bit rd_ok, wr_ok;
        if (rs) begin
            m_q.delete();
            m_ovf        = 1'b0;
            m_udf        = 1'b0;
            m_rvalid_reg = 1'b0;
            m_rdata_reg  = '0;
        end else begin
            rd_ok = r && (m_q.size() > 0);
            wr_ok = w && ((m_q.size() < DEPTH) || rd_ok);
            m_ovf = w && !wr_ok;
            m_udf = r && !rd_ok;
            m_rvalid_reg = rd_ok;
            if (rd_ok) m_rdata_reg = m_q.pop_front();
            if (wr_ok) m_q.push_back(d);
        end
    endtask

    task automatic compare();
        int n;
        n = m_q.size();
        check("f_count", 64'(f_count), 64'(n));
        check("f_empty", 64'(f_empty), 64'(n == 0));
        check("f_full", 64'(f_full), 64'(n == DEPTH));
        check("f_almost_empty", 64'(f_ae), 64'(n <= 2));
        check("f_almost_full", 64'(f_af), 64'(n >= 6));
        check("f_overflow", 64'(f_ovf), 64'(m_ovf));
        check("f_underflow", 64'(f_udf), 64'(m_udf));
        check("f_rvalid", 64'(f_rvalid), 64'(n != 0));
        if (n != 0) check("f_rdata", 64'(f_rdata), 64'(m_q[0]));
        check("r_count", 64'(r_count), 64'(n));
        check("r_empty", 64'(r_empty), 64'(n == 0));
        check("r_full", 64'(r_full), 64'(n == DEPTH));
        check("r_almost_empty", 64'(r_ae), 64'(n <= 4));
        check("r_almost_full", 64'(r_af), 64'(n >= 4));
        check("r_overflow", 64'(r_ovf), 64'(m_ovf));
        check("r_underflow", 64'(r_udf), 64'(m_udf));
        check("r_rvalid", 64'(r_rvalid), 64'(m_rvalid_reg));
        check("r_rdata", 64'(r_rdata), 64'(m_rdata_reg));
    endtask

    // One clock: drive inputs, let the edge happen, update model, sample 1ns later.
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic rs);
        wen   = w;
        ren   = r;
        wdata = d;
        rst   = rs;
        @(posedge clk);
        model_edge(w, r, d, rs);
        #1;
        compare();
    endtask

    initial begin
        m_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_rvalid_reg = 1'b0; m_rdata_reg = '0;
        wen = 1'b0; ren = 1'b0; wdata = '0; rst = 1'b1;

        // Reset state.
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        // Three writes then three reads.
        step(1, 0, 36'h1, 0);
        step(1, 0, 36'h2, 0);
        step(1, 0, 36'h3, 0);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0);
        step(0, 0, '0, 0);

        // Fill to full, overflow, simultaneous access while full, drain past empty.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 36'(32'h100 + i), 0);
        step(1, 0, 36'hBAD, 0);
        step(0, 0, '0, 0);
        step(1, 1, 36'h1FF, 0);
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, '0, 0);
        step(0, 0, '0, 0);

        // Empty FIFO with simultaneous write and read.
        step(1, 1, 36'hA5, 0);
        step(0, 0, '0, 0);
        step(0, 1, '0, 0);
        step(0, 0, '0, 0);

        // Threshold sweep up and down.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 36'(i), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, '0, 0);

        // Back-to-back registered reads.
        step(1, 0, 36'h11, 0);
        step(1, 0, 36'h22, 0);
        step(0, 1, '0, 0);
        step(0, 1, '0, 0);
        step(0, 0, '0, 0);

        // Twenty write/read pairs across pointer wrap, with a 3-deep backlog.
        for (int i = 0; i < 3; i++) step(1, 0, 36'(32'h300 + i), 0);
        for (int i = 0; i < 20; i++) step(1, 1, 36'(32'h400 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0);

        // Reset with count=5 and a write pending.
        for (int i = 0; i < 5; i++) step(1, 0, 36'(32'h500 + i), 0);
        step(1, 0, 36'h5FF, 1);
        step(0, 0, '0, 0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            logic w, r, rs;
            logic [WIDTH-1:0] d;
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 50);
            rs = ($urandom_range(0, 149) == 0);
            d  = {4'($urandom), $urandom};
            step(w, r, d, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock FIFO; same-domain successor to the dual-clock FIFO.
- Used where producer and consumer share one clock and no gray-code pointer crossing is needed.
- Adds over the dual-clock FIFO: extra-MSB pointers so full and empty are unambiguous, synchronous reset, occupancy count, programmable almost-full/almost-empty thresholds, selectable first-word-fall-through (FWFT) or registered read mode, and overflow/underflow error pulses.

Parameters:
- WIDTH, 36: data word width in bits.
- DEPTH, 256: number of entries; power of two, >= 2.
- FWFT, 1: 1 = head word presented on rdata with no read latency; 0 = rdata registered, one-cycle read latency.
- AFULL_THRESH, DEPTH-4: almost_full asserts when count >= AFULL_THRESH; range 1..DEPTH.
- AEMPTY_THRESH, 4: almost_empty asserts when count <= AEMPTY_THRESH; range 0..DEPTH-1.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- wen  in  1  write request.
- wdata  in  WIDTH  write data.
- ren  in  1  read request.
- rdata  out  WIDTH  read data.
- rvalid  out  1  rdata holds a valid word.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Pointers: wptr and rptr are $clog2(DEPTH)+1 bits. Memory is addressed by the low bits; the MSB is a wrap bit.
- empty = (wptr == rptr). full = (low bits equal and MSBs differ). count = wptr - rptr, modulo 2^($clog2(DEPTH)+1).
- All flags and count are combinational from registered pointers. A write accepted at edge N is reflected in count and flags from edge N onward, with no extra latency.
- Read acceptance: rd_acc = ren & !empty.
- Write acceptance: wr_acc = wen & (!full | rd_acc). When full, a simultaneous accepted read frees a slot, so both are accepted and count stays DEPTH.
- Empty with wen & ren: the write is accepted; the read is rejected and underflow pulses. There is no bypass of the write to the read side.
- overflow = wen & !wr_acc, registered. It pulses the cycle after the rejected request; pointers and memory are unchanged.
- underflow = ren & !rd_acc, registered, same timing as overflow.
- Each accepted access increments its pointer by 1. Wrap past DEPTH-1 is natural modular arithmetic and toggles the MSB.
- FWFT=1:
  - rdata = mem[rptr low bits], combinational; rvalid = !empty.
  - The word written at edge N appears on rdata after edge N when the FIFO was empty.
  - ren pops the presented word at the edge.
- FWFT=0:
  - On rd_acc, rdata <= mem[rptr] at the edge and rvalid pulses high for exactly one cycle after it.
  - rdata holds its last value when no read is accepted.
  - Back-to-back accepted reads give continuous rvalid.
- Reset (rst high at an edge):
  - wptr=0, rptr=0, hence count=0, empty=1, full=0, almost_empty=1.
  - almost_full=0 (AFULL_THRESH >= 1).
  - overflow=0, underflow=0, rvalid=0; rdata=0 in FWFT=0 mode.
  - Memory contents are not reset and are unreachable until rewritten.
- rst overrides wen/ren in the same cycle: no write is committed and no pulse is generated. Reset mid-burst discards all contents immediately.
- Memory is inferred as block RAM; one write port and one read port, no reset on the array.

Test Plan:
- DEPTH=8, FWFT=1: after reset, write 0x1,0x2,0x3 on consecutive cycles -> rdata=0x1 after the first edge, count=3; three reads return 0x1,0x2,0x3, then empty=1 and count=0.
- DEPTH=8: 8 writes -> full=1, count=8. A 9th write alone -> overflow pulses one cycle and count stays 8. Then wen&ren together -> both accepted, count=8, the head advances.
- Empty FIFO, wen&ren with wdata=0xA5 -> underflow pulses, count=1, rdata=0xA5 next cycle (FWFT=1).
- DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2:
  - Fill 0..8 -> almost_empty high for count<=2; almost_full rises exactly at count=6.
  - Drain -> both flags mirror the thresholds.
- FWFT=0: write 0x11,0x22; read twice back-to-back -> rvalid high two cycles, rdata 0x11 then 0x22, each one cycle after its ren edge.
- Wrap and reset:
  - Run 20 write/read pairs through DEPTH=8 -> data ordering intact across pointer wrap.
  - Assert rst with count=5 and wen=1 -> next cycle count=0, empty=1, no overflow or underflow.
